// File: rtl/sntrup_pkg.sv
// Shared widths and FSM state encoding for the hash-data pack/unpack path.
package sntrup_pkg;
    localparam int COEF_W = 11;
    localparam int BYTE_W = 8;
    localparam int ADDR_W = 11;
    localparam int ACC_W  = COEF_W + BYTE_W - 1;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/hash_data_unpack_fsm_bit_accum.sv
// Bit accumulator: appends bytes at the current fill level and consumes COEF_W bits from the bottom.
// Single-cycle update; the caller never appends and consumes in the same cycle.
module bit_accum
    import sntrup_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              append_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              consume_i,
    output logic [COEF_W-1:0] coef_o,
`ifdef PAD_CHECK_EN
    output logic              rest_nz_o,
`endif
    output logic [CNT_W-1:0]  cnt_o
);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (append_i) begin
            acc_d = acc_q | (ACC_W'(byte_i) << cnt_q);
            cnt_d = cnt_q + CNT_W'(BYTE_W);
        end else if (consume_i) begin
            acc_d = acc_q >> COEF_W;
            cnt_d = cnt_q - CNT_W'(COEF_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign coef_o = acc_q[COEF_W-1:0];
    assign cnt_o  = cnt_q;
`ifdef PAD_CHECK_EN
    // Bits above cnt are always zero, so anything above the coefficient is leftover data.
    assign rest_nz_o = |acc_q[ACC_W-1:COEF_W];
`endif
endmodule

// File: rtl/hash_data_unpack_fsm.sv
// Unpacks an LSB-first byte stream into COEF_W-bit RAM writes at 0..degp; PAD_CHECK_EN adds a nonzero-padding flag.
// First write the cycle after the 2nd accepted byte; in_ready is low outside FILL, so input stalls simply hold the FSM.
module hash_data_unpack_fsm
    import sntrup_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] degp,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [COEF_W-1:0] mem_din,
    output logic              busy,
    output logic              done,
    output logic              pad_err
);
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  degp_q, degp_d;
    logic [COEF_W-1:0]  coef;
    logic [CNT_W-1:0]   cnt;
    logic               hs;
    logic               accept_start;
    logic               fill_full;

    assign accept_start = (state_q == IDLE) && start;
    assign hs           = in_valid && in_ready;
    assign fill_full    = (cnt + CNT_W'(BYTE_W)) >= CNT_W'(COEF_W);

`ifdef PAD_CHECK_EN
    logic rest_nz;
`endif

    bit_accum u_accum (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (accept_start),
        .append_i  (hs),
        .byte_i    (in_byte),
        .consume_i (state_q == WRITE),
        .coef_o    (coef),
`ifdef PAD_CHECK_EN
        .rest_nz_o (rest_nz),
`endif
        .cnt_o     (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (hs && fill_full) state_d = WRITE;
            WRITE:   state_d = (idx_q == degp_q) ? DONE : FILL;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        done     = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = idx_q;
                mem_din  = coef;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        degp_d = degp_q;
        if (accept_start) begin
            idx_d  = '0;
            degp_d = degp;
        end else if (state_q == WRITE) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            degp_q <= '0;
        end else begin
            idx_q  <= idx_d;
            degp_q <= degp_d;
        end
    end

`ifdef PAD_CHECK_EN
    logic pad_err_q, pad_err_d;

    // Sampled on the final write, when the accumulator still holds the leftover bits.
    always_comb begin
        pad_err_d = pad_err_q;
        if (accept_start) begin
            pad_err_d = 1'b0;
        end else if (state_q == WRITE && state_d == DONE) begin
            pad_err_d = rest_nz;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_err_q <= 1'b0;
        end else begin
            pad_err_q <= pad_err_d;
        end
    end

    assign pad_err = pad_err_q;
`else
    assign pad_err = 1'b0;
`endif
endmodule
